// File: rtl/bus_demux_stream.sv
// -----------------------------------------------------------------------------
// bus_demux_stream
//   Distributes one valid/ready input stream onto PARAM_N output channels.
//   The target channel is in_sel, or an internal round-robin pointer when
//   rr_en=1. Each channel owns a one-entry registered slot, so a stalled
//   consumer blocks only words aimed at its own channel.
//
// Ports
//   clk        in   clock, all state updates on rising edge
//   rst        in   synchronous reset, active-high
//   rr_en      in   1 = round-robin target, 0 = in_sel target
//   in_sel     in   target channel when rr_en=0
//   in_valid   in   input word valid
//   in_ready   out  input word accepted this cycle when in_valid=1
//   in_data    in   input word
//   out_valid  out  per-channel valid (bit i = channel i)
//   out_ready  in   per-channel consumer ready
//   out_data   out  channel i at [(i+1)*W-1 -: W]
//   rr_ptr     out  current round-robin pointer
//   drop_err   out  1-cycle pulse: word dropped because in_sel was out of range
//   busy       out  OR of all out_valid bits
// -----------------------------------------------------------------------------
module bus_demux_stream #(
    parameter int unsigned PARAM_N         = 4,
    parameter int unsigned PARAM_BUS_WIDTH = 4,
    localparam int unsigned SEL_W = (PARAM_N > 1) ? $clog2(PARAM_N) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 rr_en,
    input  logic [SEL_W-1:0]                     in_sel,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [PARAM_BUS_WIDTH-1:0]           in_data,
    output logic [PARAM_N-1:0]                   out_valid,
    input  logic [PARAM_N-1:0]                   out_ready,
    output logic [PARAM_N*PARAM_BUS_WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]                     rr_ptr,
    output logic                                 drop_err,
    output logic                                 busy
);

    localparam int unsigned W  = PARAM_BUS_WIDTH;
    // Per-channel vectors are padded to a power of two so any SEL_W value
    // indexes safely; padded entries are never selected when tgt is valid.
    localparam int unsigned NP = 1 << SEL_W;
    localparam logic [SEL_W:0]   N_EXT  = (SEL_W + 1)'(PARAM_N);
    localparam logic [SEL_W-1:0] PTR_MAX = SEL_W'(PARAM_N - 1);

    logic [PARAM_N-1:0]   out_valid_q, out_valid_d;
    logic [PARAM_N*W-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0]     rr_ptr_q,    rr_ptr_d;
    logic                 drop_err_q,  drop_err_d;

    logic [SEL_W-1:0] tgt;
    logic             tgt_ok;
    logic [NP-1:0]    ov_pad, or_pad;
    logic             accept;

    assign tgt    = rr_en ? rr_ptr_q : in_sel;
    // The round-robin pointer never exceeds PARAM_N-1, so only in_sel can be out of range.
    assign tgt_ok = rr_en | ({1'b0, in_sel} < N_EXT);

    always_comb begin
        ov_pad = '0;
        or_pad = '0;
        ov_pad[PARAM_N-1:0] = out_valid_q;
        or_pad[PARAM_N-1:0] = out_ready;
    end

    // Invalid targets are always "ready" so the bad word is consumed and dropped.
    assign in_ready = ~rst & (tgt_ok ? (~ov_pad[tgt] | or_pad[tgt]) : 1'b1);
    assign accept   = in_valid & in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        for (int unsigned i = 0; i < PARAM_N; i++) begin
            // Load wins over drain, giving bubble-free drain+load in one cycle.
            if (accept && tgt_ok && (tgt == SEL_W'(i))) begin
                out_valid_d[i]       = 1'b1;
                out_data_d[i*W +: W] = in_data;
            end else if (out_valid_q[i] && out_ready[i]) begin
                out_valid_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && rr_en) begin
            rr_ptr_d = (rr_ptr_q == PTR_MAX) ? '0 : rr_ptr_q + 1'b1;
        end
    end

    assign drop_err_d = accept & ~tgt_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            rr_ptr_q    <= '0;
            drop_err_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rr_ptr_q    <= rr_ptr_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign rr_ptr    = rr_ptr_q;
    assign drop_err  = drop_err_q;
    assign busy      = |out_valid_q;

endmodule

// File: tb/tb_bus_demux_stream.sv
// -----------------------------------------------------------------------------
// tb_bus_demux_stream
//   Directed bench for bus_demux_stream. A 4-channel instance covers reset,
//   directed select, drain+load, round-robin and stall; a 3-channel instance
//   covers out-of-range select dropping and reset mid-operation.
// -----------------------------------------------------------------------------
module tb_bus_demux_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4-channel instance
    logic        rr_en4, in_valid4, in_ready4, drop_err4, busy4;
    logic [1:0]  in_sel4, rr_ptr4;
    logic [3:0]  in_data4, out_valid4, out_ready4;
    logic [15:0] out_data4;

    // 3-channel instance
    logic        rr_en3, in_valid3, in_ready3, drop_err3, busy3;
    logic [1:0]  in_sel3, rr_ptr3;
    logic [3:0]  in_data3;
    logic [2:0]  out_valid3, out_ready3;
    logic [11:0] out_data3;

    bus_demux_stream #(.PARAM_N(4), .PARAM_BUS_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .rr_en(rr_en4), .in_sel(in_sel4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .rr_ptr(rr_ptr4), .drop_err(drop_err4), .busy(busy4)
    );

    bus_demux_stream #(.PARAM_N(3), .PARAM_BUS_WIDTH(4)) dut3 (
        .clk(clk), .rst(rst), .rr_en(rr_en3), .in_sel(in_sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .rr_ptr(rr_ptr3), .drop_err(drop_err3), .busy(busy3)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then settled and inputs
    // may be changed well away from the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        rr_en4 = 1'b0; in_sel4 = 2'd0; in_valid4 = 1'b1; in_data4 = 4'h0; out_ready4 = 4'b0000;
        rr_en3 = 1'b0; in_sel3 = 2'd0; in_valid3 = 1'b1; in_data3 = 4'h0; out_ready3 = 3'b000;
        #1;
        chk("rst_in_ready4_c0", in_ready4, 1'b0);
        tick();
        chk("rst_in_ready4_c1", in_ready4, 1'b0);
        chk("rst_in_ready3_c1", in_ready3, 1'b0);
        tick();
        chk("rst_in_ready4", in_ready4, 1'b0);
        chk("rst_out_valid4", out_valid4, 4'b0000);
        chk("rst_out_data4", out_data4, 16'h0000);
        chk("rst_rr_ptr4", rr_ptr4, 2'd0);
        chk("rst_drop_err4", drop_err4, 1'b0);
        chk("rst_busy4", busy4, 1'b0);
        chk("rst_out_valid3", out_valid3, 3'b000);
        rst = 1'b0; in_valid4 = 1'b0; in_valid3 = 1'b0;
        tick();
        chk("idle_out_valid4", out_valid4, 4'b0000);

        // ---------------- directed select ----------------
        in_sel4 = 2'd2; in_data4 = 4'hA; in_valid4 = 1'b1;
        #1;
        chk("sel2_in_ready", in_ready4, 1'b1);
        tick();
        chk("sel2_out_valid", out_valid4, 4'b0100);
        chk("sel2_ch2_data", out_data4[11:8], 4'hA);
        chk("sel2_busy", busy4, 1'b1);
        chk("sel2_rr_hold", rr_ptr4, 2'd0);
        chk("sel2_full_in_ready", in_ready4, 1'b0);
        in_sel4 = 2'd1;
        #1;
        chk("sel1_in_ready", in_ready4, 1'b1);
        in_valid4 = 1'b0;
        #1;
        chk("sel1_ready_no_valid", in_ready4, 1'b1);
        in_sel4 = 2'd2;
        tick();
        chk("sel2_hold_valid", out_valid4, 4'b0100);
        chk("sel2_hold_data", out_data4[11:8], 4'hA);

        // ---------------- drain + load ----------------
        out_ready4 = 4'b0100; in_sel4 = 2'd2; in_data4 = 4'h5; in_valid4 = 1'b1;
        #1;
        chk("dl_in_ready", in_ready4, 1'b1);
        tick();
        chk("dl_out_valid", out_valid4, 4'b0100);
        chk("dl_ch2_data", out_data4[11:8], 4'h5);
        in_valid4 = 1'b0;
        tick();
        chk("drain_out_valid", out_valid4, 4'b0000);
        chk("drain_data_held", out_data4[11:8], 4'h5);
        chk("drain_busy", busy4, 1'b0);

        // ---------------- round-robin ----------------
        rr_en4 = 1'b1; out_ready4 = 4'b1111; in_valid4 = 1'b1;
        in_data4 = 4'h1; tick();
        chk("rr1_out_valid", out_valid4, 4'b0001);
        chk("rr1_ch0", out_data4[3:0], 4'h1);
        in_data4 = 4'h2; tick();
        chk("rr2_out_valid", out_valid4, 4'b0010);
        chk("rr2_ch1", out_data4[7:4], 4'h2);
        in_data4 = 4'h3; tick();
        chk("rr3_out_valid", out_valid4, 4'b0100);
        chk("rr3_ch2", out_data4[11:8], 4'h3);
        in_data4 = 4'h4; tick();
        chk("rr4_out_valid", out_valid4, 4'b1000);
        chk("rr4_ch3", out_data4[15:12], 4'h4);
        chk("rr4_ptr", rr_ptr4, 2'd0);
        in_data4 = 4'h5; tick();
        chk("rr5_out_valid", out_valid4, 4'b0001);
        chk("rr5_ch0", out_data4[3:0], 4'h5);
        chk("rr5_ptr", rr_ptr4, 2'd1);
        in_valid4 = 1'b0;
        tick();
        chk("rr_idle_valid", out_valid4, 4'b0000);
        chk("rr_idle_ptr", rr_ptr4, 2'd1);

        // ---------------- stall ----------------
        out_ready4 = 4'b1101; in_valid4 = 1'b1;
        in_data4 = 4'h7; tick();               // ch1 <- 7, stalled
        chk("st_ch1_load", out_data4[7:4], 4'h7);
        chk("st_ptr2", rr_ptr4, 2'd2);
        in_data4 = 4'h8; tick();               // ch2
        in_data4 = 4'h9; tick();               // ch3
        in_data4 = 4'hA; tick();               // ch0
        chk("st_ptr_back1", rr_ptr4, 2'd1);
        chk("st_out_valid", out_valid4, 4'b0011);
        in_data4 = 4'hB;
        #1;
        chk("st_in_ready0", in_ready4, 1'b0);
        tick();
        chk("st_ptr_hold", rr_ptr4, 2'd1);
        chk("st_ch1_stable", out_data4[7:4], 4'h7);
        chk("st_valid_after", out_valid4, 4'b0010);
        rr_en4 = 1'b0; in_sel4 = 2'd3;
        #1;
        chk("st_indep_ch3", in_ready4, 1'b1);
        rr_en4 = 1'b1;
        out_ready4 = 4'b1111;
        #1;
        chk("st_resume_ready", in_ready4, 1'b1);
        tick();
        chk("st_resume_ptr", rr_ptr4, 2'd2);
        chk("st_resume_ch1", out_data4[7:4], 4'hB);
        chk("st_resume_valid", out_valid4, 4'b0010);
        in_valid4 = 1'b0;
        tick();

        // ---------------- invalid select (N=3) ----------------
        in_sel3 = 2'd0; in_data3 = 4'h6; in_valid3 = 1'b1;
        tick();
        chk("inv_pre_valid", out_valid3, 3'b001);
        in_sel3 = 2'd3; in_data3 = 4'hF;
        #1;
        chk("inv_in_ready", in_ready3, 1'b1);
        chk("inv_no_err_yet", drop_err3, 1'b0);
        tick();
        chk("inv_drop_err", drop_err3, 1'b1);
        chk("inv_valid_same", out_valid3, 3'b001);
        chk("inv_data_same", out_data3, 12'h006);
        chk("inv_rr_ptr", rr_ptr3, 2'd0);
        in_valid3 = 1'b0;
        tick();
        chk("inv_err_pulse", drop_err3, 1'b0);

        // ---------------- reset mid-operation ----------------
        rst = 1'b1;
        tick();
        chk("mid_rst_valid3", out_valid3, 3'b000);
        chk("mid_rst_data3", out_data3, 12'h000);
        rst = 1'b0;
        tick();
        chk("post_rst_valid3", out_valid3, 3'b000);
        chk("post_rst_ptr4", rr_ptr4, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net: the directed sequence is short, so this bound is generous.
    initial begin
        #20000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
